fdiv_iter: RTL
==============

Name: fdiv_iter

Overview:
- Multi-cycle single-precision floating-point divider, y = x1 / x2. It is the inverse operation of the combinational fmul and sits beside it in the FPU.
- Output format and exception conventions match fmul: denormals flushed, `ovf` flag on exponent overflow, no NaN generation.
- Uses a radix-2 restoring mantissa divider, one quotient bit per clock, with a valid/ready start handshake and a single-cycle result pulse.

Parameters:
- QBITS, 26, number of quotient bits produced. Covers 24 mantissa bits, 1 guard bit and 1 normalisation bit. Must be at least 26.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- x1  in  32  dividend (IEEE-754 single precision); sampled on the accept edge.
- x2  in  32  divisor (IEEE-754 single precision); sampled on the accept edge.
- ready  out  1  high only in state IDLE with rst low.
- y  out  32  quotient; registered; held until the next result.
- ovf  out  1  exponent-overflow or divide-by-zero flag; registered; held with y.
- valid  out  1  one-cycle pulse marking a new y/ovf.

Behaviour:
- Reset:
  - State goes to IDLE; y=0, ovf=0, valid=0, count=0.
  - ready=0 while rst=1.
  - Reset mid-operation abandons the division with no valid pulse. ready=1 on the first cycle after rst falls.
- States: IDLE -> DIV -> RND -> IDLE.
  - IDLE: on start&&ready, latch the sign s=x1[31]^x2[31] and both operands, and load rem={1'b0,1,m1} (25b), count=0. Go to DIV. start is ignored when ready=0.
  - DIV: on each edge, if rem >= {1'b0,1,m2} then q bit=1 and rem -= divisor, else q bit=0. Then rem <<= 1 and count++. Quotient bits fill q[QBITS-1] downward. After QBITS edges go to RND.
  - RND: normalise, round, pack; register y, ovf and valid=1; go to IDLE.
- Latency: the result is registered on the (QBITS+1)th edge after the accept edge, i.e. the 27th by default.
  - valid is high in the cycle that follows, together with ready=1.
  - A start in that cycle is accepted, so back-to-back throughput is one result per 28 cycles.
- Exponent arithmetic: 10-bit signed, e = e1 - e2 + 127.
- Normalisation:
  - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0] | (rem!=0).
  - Otherwise: mant=q[24:1], guard=q[0], sticky=(rem!=0), and e -= 1.
- Rounding: round-to-nearest-even. Increment if guard & (sticky | mant[0]). A carry out of mant gives mant=1.0 and e += 1.
- Special cases, resolved in RND; priority follows list order:
  1. x2 exponent == 0 (zero or denormal divisor) gives y={s,8'hFF,23'b0}, ovf=1. This includes 0/0.
  2. x1 exponent == 0 gives y={s,31'b0}, ovf=0.
  3. Final e >= 255 gives y={s,8'hFF,23'b0}, ovf=1.
  4. Final e <= 0 (underflow) flushes to y={s,31'b0}, ovf=0.
- Operands with exponent 255 are treated as ordinary normal numbers with no NaN/inf semantics. The bench excludes them from checks.
- x1/x2 changing after the accept edge has no effect.

Decomposition:
- fpu_pkg holds:
  - the float32 struct typedef {sign, exp[7:0], man[22:0]};
  - BIAS=127, EXP_MAX=255;
  - the INF_MAG constant 31'h7F800000;
  - the state enum {IDLE, DIV, RND}.
- One sub-module, fdiv_round (combinational): takes s, e, q, rem_nz and the special-case flags, and returns {y, ovf}. It is instantiated once and keeps the FSM file small.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0 / 2.0): y=0x40400000, ovf=0, valid exactly 27 edges after accept, ready low in between.
- 0x3F800000 / 0x40400000 (1 / 3): y=0x3EAAAAAB. Exercises the RNE round-up and the q[25]=0 normalise path.
- 0xBF800000 / 0x00000000 (-1 / 0): y=0xFF800000, ovf=1. Also 0x00000000 / 0x40A00000 (0 / 5): y=0x00000000, ovf=0.
- 0x7F000000 / 0x00800000: y=0x7F800000, ovf=1. 0x00800000 / 0x40000000: y=0x00000000, ovf=0 (underflow flush).
- Assert rst for one cycle at edge 10 of a division: no valid pulse, y=0, ready=1 after release. The next start 0x41200000 / 0x40A00000 (10 / 5) gives y=0x40000000.
- Back-to-back: start held high across the valid cycle gives the second result 28 cycles after the first. Then run 10^5 random normal operand pairs against a shortreal x1/x2 model, flushing the model's denormal results.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float32 type, exponent constants and divider state encoding.
//   float32_t : packed {sign, exp[7:0], man[22:0]}
//   BIAS, EXP_MAX, INF_MAG : exponent bias, saturation exponent, infinity magnitude
//   state_t   : divider FSM states IDLE/DIV/RND
package fpu_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;
    localparam int BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [30:0] INF_MAG = 31'h7F800000;
    typedef enum logic [1:0] {IDLE, DIV, RND} state_t;
endpackage

// File: rtl/fdiv_iter_if.sv
// fdiv_iter_if: start/result handshake bundle of the iterative divider.
//   start, x1, x2 : request and operands (master -> slave)
//   ready         : slave can accept a request
//   y, ovf, valid : result, overflow/div-by-zero flag, one-cycle result strobe
interface fdiv_iter_if;
    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ready;
    logic [31:0] y;
    logic        ovf;
    logic        valid;
    modport master (output start, x1, x2, input ready, y, ovf, valid);
    modport slave (input start, x1, x2, output ready, y, ovf, valid);
endinterface

// File: rtl/fdiv_round.sv
// fdiv_round: normalise, round-to-nearest-even and pack the raw quotient.
//   s       : result sign
//   e       : unnormalised biased exponent e1 - e2 + BIAS (10-bit signed)
//   q       : raw quotient bits, q[QBITS-1] weighs 2^0
//   rem_nz  : final partial remainder is nonzero (feeds sticky)
//   x1_zero : dividend exponent is zero; x2_zero : divisor exponent is zero
//   y, ovf  : packed result and overflow/div-by-zero flag
module fdiv_round
    import fpu_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic              s,
    input  logic signed [9:0] e,
    input  logic [QBITS-1:0]  q,
    input  logic              rem_nz,
    input  logic              x1_zero,
    input  logic              x2_zero,
    output logic [31:0]       y,
    output logic              ovf
);
    // Bits below the guard position; they shift by one when the quotient is < 1.
    localparam logic [QBITS-1:0] LOW_HI = {{25{1'b0}}, {(QBITS-25){1'b1}}};
    localparam logic [QBITS-1:0] LOW_LO = LOW_HI >> 1;
    localparam logic signed [9:0] EMAX = 10'(EXP_MAX);
    logic              top;
    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [23:0]       fr;
    logic signed [9:0] ef;
    always_comb begin
        top    = q[QBITS-1];
        frac   = top ? q[QBITS-2 -: 23] : q[QBITS-3 -: 23];
        guard  = top ? q[QBITS-25] : q[QBITS-26];
        sticky = rem_nz | (|(q & (top ? LOW_HI : LOW_LO)));
        inc    = guard & (sticky | frac[0]);
        // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0.
        fr     = {1'b0, frac} + 24'(inc);
        ef     = e + (top ? 10'sd0 : -10'sd1) + (fr[23] ? 10'sd1 : 10'sd0);
        y      = x2_zero    ? {s, INF_MAG} :
                 x1_zero    ? {s, 31'b0} :
                 ef >= EMAX ? {s, INF_MAG} :
                 ef <= 10'sd0 ? {s, 31'b0} : {s, ef[7:0], fr[22:0]};
        ovf    = x2_zero | (~x1_zero & (ef >= EMAX));
    end
endmodule

// File: rtl/fdiv_iter.sv
// fdiv_iter: multi-cycle float32 divider y = x1 / x2, one quotient bit per clock.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of fdiv_iter_if (start/x1/x2 in, ready/y/ovf/valid out)
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_iter_if.slave  bus
);
    localparam int CW = $clog2(QBITS + 1);
    float32_t          fx1;
    float32_t          fx2;
    state_t            state_q, state_d;
    logic              s_q, s_d;
    logic signed [9:0] e_q, e_d;
    logic              x1z_q, x1z_d;
    logic              x2z_q, x2z_d;
    logic [22:0]       m2_q, m2_d;
    logic [24:0]       rem_q, rem_d;
    logic [QBITS-1:0]  q_q, q_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       y_q, y_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [24:0]       dvs;
    logic              ge;
    logic [24:0]       diff;
    logic [31:0]       r_y;
    logic              r_ovf;

    fdiv_round #(.QBITS(QBITS)) u_round (
        .s       (s_q),
        .e       (e_q),
        .q       (q_q),
        .rem_nz  (|rem_q),
        .x1_zero (x1z_q),
        .x2_zero (x2z_q),
        .y       (r_y),
        .ovf     (r_ovf)
    );

    always_comb begin
        fx1     = bus.x1;
        fx2     = bus.x2;
        dvs     = {2'b01, m2_q};
        ge      = rem_q >= dvs;
        // Remainder stays below the divisor (< 2^24), so the shift never loses a bit.
        diff    = ge ? rem_q - dvs : rem_q;
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        x1z_d   = x1z_q;
        x2z_d   = x2z_q;
        m2_d    = m2_q;
        rem_d   = rem_q;
        q_d     = q_q;
        count_d = count_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (state_q == IDLE && bus.start) begin
            s_d     = fx1.sign ^ fx2.sign;
            e_d     = 10'(fx1.exp) - 10'(fx2.exp) + 10'(BIAS);
            x1z_d   = fx1.exp == 8'd0;
            x2z_d   = fx2.exp == 8'd0;
            m2_d    = fx2.man;
            rem_d   = {2'b01, fx1.man};
            q_d     = '0;
            count_d = '0;
            state_d = DIV;
        end else if (state_q == DIV) begin
            q_d     = {q_q[QBITS-2:0], ge};
            rem_d   = diff << 1;
            count_d = count_q + CW'(1);
            state_d = count_q == CW'(QBITS - 1) ? RND : DIV;
        end else if (state_q == RND) begin
            y_d     = r_y;
            ovf_d   = r_ovf;
            valid_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= '0;
            x1z_q   <= 1'b0;
            x2z_q   <= 1'b0;
            m2_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            x1z_q   <= x1z_d;
            x2z_q   <= x2z_d;
            m2_q    <= m2_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            count_q <= count_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready = state_q == IDLE && !rst;
    assign bus.y     = y_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;
endmodule
